// File: rtl/lpf_coeff_sequencer.sv
// Coefficient sequencer: shadow/live banks, atomic commit, DSP coefficient CE pulse and output blanking.
// Optional feature macro LPF_COEFF_FLUSH_EN adds the FLUSH state and blank_o; without it LOAD goes straight to DONE.
module lpf_coeff_sequencer #(
  parameter int                      COEFF_BITS   = 18,
  parameter int                      FLUSH_CYCLES = 12,
  parameter logic [8*COEFF_BITS-1:0] INIT_COEFFS  = {18'h10342, -18'h3216, 18'h1672, -18'h949,
                                                     18'h526, -18'h263, 18'h105, 18'h23},
  localparam int                     NCOEFF       = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         wr_valid_i,
  input  logic [2:0]                   wr_addr_i,
  input  logic [COEFF_BITS-1:0]        wr_data_i,
  output logic                         wr_ready_o,
  input  logic                         commit_i,
  output logic [NCOEFF*COEFF_BITS-1:0] coeff_o,
  output logic                         coeff_ce_o,
  output logic                         blank_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         err_o
);

  if (FLUSH_CYCLES < 1) begin : g_flush_check
    $error("FLUSH_CYCLES must be at least 1");
  end

`ifdef LPF_COEFF_FLUSH_EN
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;
  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);
  logic [CNT_W-1:0] cnt;
`else
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
`endif

  state_t state, state_nxt;

  logic [COEFF_BITS-1:0] shadow [NCOEFF];
  logic [NCOEFF-1:0]     mask;
  logic [NCOEFF-1:0]     mask_eff;
  logic                  wr_fire;
  logic                  commit_ok;
  logic                  commit_bad;

  assign wr_ready_o = (state != LOAD);
  assign wr_fire    = wr_valid_i & wr_ready_o;

  // A write landing on the same edge as the commit counts toward completeness.
  always_comb begin
    mask_eff = mask;
    if (wr_fire) mask_eff[wr_addr_i] = 1'b1;
  end

  assign commit_ok  = commit_i & (state == IDLE) & (&mask_eff);
  assign commit_bad = commit_i & ~commit_ok;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy_o    = (state != IDLE);
    done_o    = (state == DONE);
    blank_o   = 1'b0;
    case (state)
      IDLE: if (commit_ok) state_nxt = LOAD;
`ifdef LPF_COEFF_FLUSH_EN
      LOAD: begin
        blank_o   = 1'b1;
        state_nxt = FLUSH;
      end
      FLUSH: begin
        blank_o = 1'b1;
        if (cnt == '0) state_nxt = DONE;
      end
`else
      LOAD: state_nxt = DONE;
`endif
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NCOEFF; i++)
        shadow[i] <= INIT_COEFFS[i*COEFF_BITS +: COEFF_BITS];
      mask       <= '0;
      coeff_o    <= INIT_COEFFS;
      coeff_ce_o <= 1'b0;
      err_o      <= 1'b0;
`ifdef LPF_COEFF_FLUSH_EN
      cnt        <= '0;
`endif
    end else begin
      coeff_ce_o <= 1'b0;
      err_o      <= commit_bad;
      if (wr_fire) shadow[wr_addr_i] <= wr_data_i;
      if (commit_ok) mask <= '0;
      else           mask <= mask_eff;
      if (state == LOAD) begin
        for (int unsigned i = 0; i < NCOEFF; i++)
          coeff_o[i*COEFF_BITS +: COEFF_BITS] <= shadow[i];
        coeff_ce_o <= 1'b1;
`ifdef LPF_COEFF_FLUSH_EN
        cnt        <= CNT_W'(FLUSH_CYCLES - 1);
`endif
      end
`ifdef LPF_COEFF_FLUSH_EN
      else if (state == FLUSH && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
`endif
    end
  end

endmodule
